// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Load/store unit sitting between the core's MEM stage and a word-addressed
// data memory (synchronous write, asynchronous read). Handles one byte-addressed
// request at a time (lb/lbu/lh/lhu/lw/sb/sh/sw). Load data is sign/zero
// extended. Sub-word stores use read-modify-write. Misaligned or illegal-size
// accesses are flagged without touching memory.
//
// Ports
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_req               request strobe, only looked at while idle
//   i_we                1 = store, 0 = load
//   i_size              00 byte, 01 half, 10 word, 11 illegal
//   i_unsigned          loads: 1 = zero-extend, 0 = sign-extend
//   i_addr              byte address (upper bits wrap modulo memory size)
//   i_wdata             right-aligned store data
//   o_busy              high while a request is in flight
//   o_done              one-cycle completion pulse
//   o_err               one-cycle error pulse, coincident with o_done
//   o_rdata             extended load result, held until the next good load
//   o_mem_addr          word index to memory
//   o_mem_data          write data to memory
//   o_mem_we            memory write enable (exactly one cycle per store)
//   i_mem_data          asynchronous read data from memory
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [31:0]           i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [31:0]           o_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic                  o_mem_we,
  input  logic [DATA_WIDTH-1:0] i_mem_data
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_RMW_READ = 3'd2,
    S_WRITE    = 3'd3,
    S_RESP     = 3'd4,
    S_RESP_ERR = 3'd5
  } state_t;

  state_t                  state_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;
  logic [31:0]             rdata_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_data_q;
  logic                    mem_we_q;
  logic [1:0]              size_q;
  logic [1:0]              lane_q;
  logic                    unsigned_q;
  logic [31:0]             wdata_q;

  logic [31:0]             rdata_d;
  logic [31:0]             merged_d;
  logic                    misaligned_s;
  logic                    addr_unused_s;

  // Alignment rule: half needs addr[0]=0, word needs addr[1:0]=0, size 11 never legal.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] low);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = low[0];
      2'b10:   bad = (low != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Pick the addressed lane out of a memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   res = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Overlay the right-aligned store data onto the selected lane(s) of the old word.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [1:0] lane, input logic [1:0] size);
    logic [31:0] res;
    res = old;
    case (size)
      2'b00: begin
        case (lane)
          2'd0:    res[7:0]   = wdata[7:0];
          2'd1:    res[15:8]  = wdata[7:0];
          2'd2:    res[23:16] = wdata[7:0];
          default: res[31:24] = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (lane[1]) res[31:16] = wdata[15:0];
        else         res[15:0]  = wdata[15:0];
      end
      default: res = wdata;
    endcase
    return res;
  endfunction

  assign misaligned_s  = access_bad(i_size, i_addr[1:0]);
  assign rdata_d       = load_extend(i_mem_data, lane_q, size_q, unsigned_q);
  assign merged_d      = store_merge(i_mem_data, wdata_q, lane_q, size_q);
  // Address bits above the memory index are deliberately ignored (wrap-around).
  assign addr_unused_s = ^i_addr[31:ADDR_WIDTH+2];

  // Request FSM; every output is a register updated alongside the state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'd0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      size_q     <= 2'b00;
      lane_q     <= 2'b00;
      unsigned_q <= 1'b0;
      wdata_q    <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q   <= 1'b0;
          err_q    <= 1'b0;
          mem_we_q <= 1'b0;
          if (i_req) begin
            busy_q     <= 1'b1;
            size_q     <= i_size;
            lane_q     <= i_addr[1:0];
            unsigned_q <= i_unsigned;
            wdata_q    <= i_wdata;
            if (misaligned_s) begin
              // Error responds on the very next cycle; memory outputs untouched.
              state_q <= S_RESP_ERR;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (!i_we) begin
              state_q    <= S_LOAD;
              mem_addr_q <= i_addr[ADDR_WIDTH+1:2];
            end else if (i_size == 2'b10) begin
              // Full word: no read needed, write straight away.
              state_q    <= S_WRITE;
              mem_addr_q <= i_addr[ADDR_WIDTH+1:2];
              mem_data_q <= i_wdata;
              mem_we_q   <= 1'b1;
            end else begin
              state_q    <= S_RMW_READ;
              mem_addr_q <= i_addr[ADDR_WIDTH+1:2];
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_LOAD: begin
          rdata_q <= rdata_d;
          done_q  <= 1'b1;
          state_q <= S_RESP;
        end
        S_RMW_READ: begin
          mem_data_q <= merged_d;
          mem_we_q   <= 1'b1;
          state_q    <= S_WRITE;
        end
        S_WRITE: begin
          mem_we_q <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_RESP;
        end
        S_RESP, S_RESP_ERR: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          err_q    <= 1'b0;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_rdata    = rdata_q;
  assign o_mem_addr = mem_addr_q;
  assign o_mem_data = mem_data_q;
  assign o_mem_we   = mem_we_q;

endmodule
